// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the writeback queue.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Register $0 is hardwired to zero and is never written.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // One pending register-file write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Newest-match search over age-ordered pending entries.
// Slot 0 is the oldest and slot N-1 the newest. Only occupied slots take part.
module wb_fwd_match
  import mips_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [N-1:0]              occ,
  input  logic [N-1:0][ADDR_W-1:0]  tags,
  input  logic [N-1:0][DATA_W-1:0]  vals,
  output logic                      hit,
  output logic [DATA_W-1:0]         data
);

  // Scan oldest to newest so the last match seen (the newest) wins; $0 never hits.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < N; k++) begin
      if (occ[k] && (tags[k] == addr) && (addr != REG_ZERO)) begin
        hit  = 1'b1;
        data = vals[k];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue feeding the register file's single write port.
// Takes results from the load path and the ALU path, drains one per clock,
// and offers two forwarding lookups over the entries still pending.
//
// Handshake: a source transfers at a rising edge where valid && ready are
// both high. Readies depend only on the registered count (and mem_valid for
// alu_ready), never on the same-cycle drain, so they are glitch-free
// relative to the register file. A transfer to $0 completes but stores nothing.
module wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_addr,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    regWrite,
  output logic [ADDR_W-1:0]       regWaddr,
  output logic [DATA_W-1:0]       wdata,
  input  logic [ADDR_W-1:0]       fwd1addr,
  input  logic [ADDR_W-1:0]       fwd2addr,
  output logic                    fwd1hit,
  output logic                    fwd2hit,
  output logic [DATA_W-1:0]       fwd1data,
  output logic [DATA_W-1:0]       fwd2data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   free;
  logic            mem_enq;
  logic            alu_enq;
  logic            deq;
  logic [CW-1:0]   enq_n;
  logic [PW-1:0]   alu_slot;

  assign free      = CW'(DEPTH) - count;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // The alu source yields a lone free slot to the mem source.
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid);

  assign mem_enq   = mem_valid && mem_ready && (mem_addr != REG_ZERO);
  assign alu_enq   = alu_valid && alu_ready && (alu_addr != REG_ZERO);
  assign enq_n     = CW'(mem_enq) + CW'(alu_enq);
  assign deq       = !empty;

  // The mem entry is older, so the alu entry lands behind it when both enqueue.
  assign alu_slot  = wr_ptr + PW'(mem_enq);

  assign regWrite  = !empty;
  assign regWaddr  = q[rd_ptr].addr;
  assign wdata     = q[rd_ptr].data;

  // Storage, pointers and occupancy; reset discards everything still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (mem_enq) q[wr_ptr]   <= wb_entry_t'{addr: mem_addr, data: mem_data};
      if (alu_enq) q[alu_slot] <= wb_entry_t'{addr: alu_addr, data: alu_data};
      wr_ptr <= wr_ptr + PW'(enq_n);
      rd_ptr <= rd_ptr + PW'(deq);
      count  <= count + enq_n - CW'(deq);
    end
  end

  logic [DEPTH-1:0]             occ;
  logic [DEPTH-1:0][ADDR_W-1:0] ord_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;

  // Rotate storage into age order (slot 0 = head) and mark occupied slots.
  always_comb begin
    occ      = '0;
    ord_addr = '0;
    ord_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ[k]      = (CW'(k) < count);
      ord_addr[k] = q[rd_ptr + PW'(k)].addr;
      ord_data[k] = q[rd_ptr + PW'(k)].data;
    end
  end

  wb_fwd_match #(.N(DEPTH)) u_fwd1 (
    .addr (fwd1addr),
    .occ  (occ),
    .tags (ord_addr),
    .vals (ord_data),
    .hit  (fwd1hit),
    .data (fwd1data)
  );

  wb_fwd_match #(.N(DEPTH)) u_fwd2 (
    .addr (fwd2addr),
    .occ  (occ),
    .tags (ord_addr),
    .vals (ord_data),
    .hit  (fwd2hit),
    .data (fwd2data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=4).
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready, alu_valid, alu_ready;
  logic [4:0]  mem_addr, alu_addr;
  logic [31:0] mem_data, alu_data;
  logic        regWrite;
  logic [4:0]  regWaddr;
  logic [31:0] wdata;
  logic [4:0]  fwd1addr, fwd2addr;
  logic        fwd1hit, fwd2hit;
  logic [31:0] fwd1data, fwd2data;
  logic [2:0]  count;
  logic        full, empty;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int enq_pending = 0;
  logic [36:0] exp_q[$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .regWrite(regWrite), .regWaddr(regWaddr), .wdata(wdata),
    .fwd1addr(fwd1addr), .fwd2addr(fwd2addr),
    .fwd1hit(fwd1hit), .fwd2hit(fwd2hit), .fwd1data(fwd1data), .fwd2data(fwd2data),
    .count(count), .full(full), .empty(empty)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && regWrite) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", regWrite, 1'b0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_addr", regWaddr, e[36:32]);
        check("wr_data", wdata, e[31:0]);
      end
    end
  end

  // Driver: apply sources for this cycle, check handshake/status against the
  // occupancy model, and record entries that will be accepted at the next edge.
  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    int  fr;
    logic exp_mr, exp_ar;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
    fr     = DEPTH - exp_cnt;
    exp_mr = (fr >= 1);
    exp_ar = (fr >= 2) || (fr >= 1 && !mv);
    check("mem_ready", mem_ready, exp_mr);
    check("alu_ready", alu_ready, exp_ar);
    check("count", count, exp_cnt);
    check("empty", empty, exp_cnt == 0);
    check("full", full, exp_cnt == DEPTH);
    enq_pending = 0;
    if (mv && exp_mr && ma != 5'd0) begin exp_q.push_back({ma, md}); enq_pending++; end
    if (av && exp_ar && aa != 5'd0) begin exp_q.push_back({aa, ad}); enq_pending++; end
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    exp_cnt = exp_cnt + enq_pending - ((exp_cnt != 0) ? 1 : 0);
    enq_pending = 0;
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && !empty; i++) begin
      idle();
      tick();
    end
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    fwd1addr = 0; fwd2addr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_regwrite", regWrite, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b1);
    rst = 1'b0;

    // Single ALU write: visible on the write port one cycle after acceptance.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'd10);
    tick();
    check("t1_regwrite", regWrite, 1'b1);
    check("t1_waddr", regWaddr, 5'd8);
    check("t1_wdata", wdata, 32'd10);
    idle();
    tick();
    check("t1_empty", empty, 1'b1);

    // Dual accept: mem {9,6} is older than alu {9,4}; forwarding sees the newest.
    drive(1'b1, 5'd9, 32'd6, 1'b1, 5'd9, 32'd4);
    tick();
    fwd1addr = 5'd9; fwd2addr = 5'd9;
    idle();
    check("t2_count", count, 2);
    check("t2_head", wdata, 32'd6);
    check("t2_fwd1hit", fwd1hit, 1'b1);
    check("t2_fwd1data", fwd1data, 32'd4);
    check("t2_fwd2data", fwd2data, 32'd4);
    tick();
    idle();
    check("t2_head2", wdata, 32'd4);
    check("t2_fwd1data_b", fwd1data, 32'd4);
    tick();
    idle();
    check("t2_fwd_after", fwd1hit, 1'b0);
    check("t2_fwd_after_d", fwd1data, 32'd0);

    // $0 destination: handshake completes, nothing queued.
    fwd1addr = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd77);
    check("t3_fwd0", fwd1hit, 1'b0);
    tick();
    idle();
    check("t3_count", count, 0);
    check("t3_nowrite", regWrite, 1'b0);
    check("t3_fwd0_b", fwd1hit, 1'b0);
    drive(1'b1, 5'd0, 32'd11, 1'b1, 5'd5, 32'd55);
    tick();
    idle();
    check("t3_count_b", count, 1);
    check("t3_waddr", regWaddr, 5'd5);
    drain("t3");

    // Backpressure: both sources always valid; the model tracks readies.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'(1 + (i % 31)), 32'(1000 + i), 1'b1, 5'(1 + ((i + 7) % 31)), 32'(2000 + i));
      tick();
    end
    drain("t4");

    // Wrap-around: ten ALU results; each is the head and the only hit next cycle.
    for (int i = 0; i < 10; i++) begin
      fwd1addr = 5'(8 + i);
      fwd2addr = 5'(7 + i);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + i), 32'(100 + i));
      tick();
      idle();
      check("t5_waddr", regWaddr, 8 + i);
      check("t5_fwdhit", fwd1hit, 1'b1);
      check("t5_fwd", fwd1data, 100 + i);
      check("t5_old_miss", fwd2hit, 1'b0);
    end
    fwd1addr = 5'd20;
    drive(1'b1, 5'd20, 32'd1, 1'b1, 5'd20, 32'd2);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'd3);
    check("t5_dup_fwd", fwd1data, 32'd2);
    tick();
    idle();
    check("t5_dup_fwd_new", fwd1data, 32'd3);
    drain("t5");

    // Reset mid-operation: three pending entries discarded.
    drive(1'b1, 5'd3, 32'd30, 1'b1, 5'd4, 32'd40);
    tick();
    drive(1'b1, 5'd5, 32'd50, 1'b1, 5'd6, 32'd60);
    tick();
    check("t6_count", count, 3);
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'd70;
    alu_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_valid = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    enq_pending = 0;
    fwd1addr = 5'd7; fwd2addr = 5'd5;
    #1;
    check("t6_count0", count, 0);
    check("t6_regwrite", regWrite, 1'b0);
    check("t6_waddr", regWaddr, 5'd0);
    check("t6_wdata", wdata, 32'd0);
    check("t6_empty", empty, 1'b1);
    check("t6_full", full, 1'b0);
    check("t6_fwd1hit", fwd1hit, 1'b0);
    check("t6_fwd2hit", fwd2hit, 1'b0);
    check("t6_fwd1data", fwd1data, 32'd0);
    check("t6_fwd2data", fwd2data, 32'd0);
    check("t6_mem_ready", mem_ready, 1'b1);
    check("t6_alu_ready", alu_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle();
      tick();
    end
    check("t6_still_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
